mod_exp_ctrl: RTL

- Initiator-side sequencer for the Montgomery multiplier: computes result = base^exponent mod modulus by left-to-right square-and-multiply.
- Drives the multiplier's md_start/md_end handshake and operand buses, and captures each product.
- Sits between the RSA top-level register block and the multiplier; the multiplier is an external instance wired to the mm_* and md_* ports.

---
 rtl/mod_exp_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external Montgomery multiplier
module mod_exp_ctrl #(
    parameter int W       = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [7:0]   e_len,
    input  logic [7:0]   m_len,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exponent,
    input  logic [W-1:0] modulus,
    input  logic [W-1:0] r2_mod,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [W-1:0] result,
    output logic         md_start,
    output logic [7:0]   mm_len,
    output logic [W-1:0] mm_a,
    output logic [W-1:0] mm_b,
    output logic [W-1:0] mm_n,
    input  logic         md_end,
    input  logic [W-1:0] mm_result
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, CONV_X, CONV_A, SQR, MUL, CONV_OUT, DONE} state_t;
    typedef enum logic [1:0] {ISSUE, WAIT, RELEASE} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          elen_zero_q, elen_zero_d;
    logic [W-1:0]  exp_q, exp_d, base_q, base_d, r2_q, r2_d, n_q, n_d;
    logic [W-1:0]  x_q, x_d, a_q, a_d, result_q, result_d;
    logic [W-1:0]  mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic [7:0]    mlen_q, mlen_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic          md_start_q, md_start_d, md_end_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    elen_c;
    logic [W-1:0]  op_a, op_b;
    logic          capture;

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign result   = result_q;
    assign md_start = md_start_q;
    assign mm_len   = mlen_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_n     = n_q;

    assign elen_c  = (int'(e_len) > W) ? 8'(W) : e_len;
    // Only the rising edge of md_end counts, so a 2-cycle md_end is captured once.
    assign capture = (phase_q == WAIT) && md_end && !md_end_q;

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            CONV_X:   begin op_a = base_q; op_b = r2_q;   end
            CONV_A:   begin op_a = W'(1);  op_b = r2_q;   end
            SQR:      begin op_a = a_q;    op_b = a_q;    end
            MUL:      begin op_a = a_q;    op_b = x_q;    end
            CONV_OUT: begin op_a = a_q;    op_b = W'(1);  end
            default:  begin op_a = '0;     op_b = '0;     end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        elen_zero_d = elen_zero_q;
        exp_d       = exp_q;
        base_d      = base_q;
        r2_d        = r2_q;
        n_d         = n_q;
        x_d         = x_q;
        a_d         = a_q;
        result_d    = result_q;
        mm_a_d      = mm_a_q;
        mm_b_d      = mm_b_q;
        mlen_d      = mlen_q;
        busy_d      = busy_q;
        error_d     = error_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        md_start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    elen_zero_d = (elen_c == 8'd0);
                    idx_d       = IW'(elen_c - 8'd1);
                    exp_d       = exponent;
                    base_d      = base;
                    r2_d        = r2_mod;
                    n_d         = modulus;
                    mlen_d      = m_len;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    phase_d     = ISSUE;
                    state_d     = CONV_X;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                case (phase_q)
                    ISSUE: begin
                        md_start_d = 1'b1;
                        mm_a_d     = op_a;
                        mm_b_d     = op_b;
                        cnt_d      = '0;
                        phase_d    = WAIT;
                    end
                    WAIT: begin
                        if (capture) begin
                            if (state_q == CONV_X) x_d = mm_result;
                            else                   a_d = mm_result;
                            phase_d = RELEASE;
                        end else if (TIMEOUT != 0) begin
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_d == CW'(TIMEOUT)) begin
                                error_d  = 1'b1;
                                result_d = '0;
                                done_d   = 1'b1;
                                busy_d   = 1'b0;
                                state_d  = DONE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (!md_end) begin
                            phase_d = ISSUE;
                            case (state_q)
                                CONV_X: state_d = CONV_A;
                                CONV_A: state_d = elen_zero_q ? CONV_OUT : SQR;
                                SQR, MUL: begin
                                    if (state_q == SQR && exp_q[idx_q]) begin
                                        state_d = MUL;
                                    end else if (idx_q == '0) begin
                                        state_d = CONV_OUT;
                                    end else begin
                                        idx_d   = idx_q - 1'b1;
                                        state_d = SQR;
                                    end
                                end
                                CONV_OUT: begin
                                    result_d = a_q;
                                    done_d   = 1'b1;
                                    busy_d   = 1'b0;
                                    state_d  = DONE;
                                end
                                default: state_d = IDLE;
                            endcase
                        end
                    end
                    default: phase_d = ISSUE;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            phase_q     <= ISSUE;
            idx_q       <= '0;
            elen_zero_q <= 1'b0;
            exp_q       <= '0;
            base_q      <= '0;
            r2_q        <= '0;
            n_q         <= '0;
            x_q         <= '0;
            a_q         <= '0;
            result_q    <= '0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            mlen_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            md_start_q  <= 1'b0;
            md_end_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            elen_zero_q <= elen_zero_d;
            exp_q       <= exp_d;
            base_q      <= base_d;
            r2_q        <= r2_d;
            n_q         <= n_d;
            x_q         <= x_d;
            a_q         <= a_d;
            result_q    <= result_d;
            mm_a_q      <= mm_a_d;
            mm_b_q      <= mm_b_d;
            mlen_q      <= mlen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            md_start_q  <= md_start_d;
            md_end_q    <= md_end;
            cnt_q       <= cnt_d;
        end
    end
endmodule
